coinc_readout_arb: RTL and testbench
====================================

Name: coinc_readout_arb

Overview:
- Collects per-cable coincidence verdicts (pcoinc/ncoinc) from the MCU coincidence logic for all 8 cables.
- Time-stamps each verdict and shares a single 32-bit event FIFO between the 8 requesters using a round-robin arbiter.
- The FIFO is drained by the register-file bus readout, one word per read strobe; a saturating drop counter reports lost events.

Parameters:
- NREQ, 8, number of requesters (cable order A1..A4 = 0..3, B1..B4 = 4..7); NREQ ≤ 8.
- DEPTH, 16, FIFO depth in words; power of 2, ≥ 2.
- TSW, 24, timestamp counter width; ≤ 24.

Ports:
- clk  in  1  100 MHz system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = capture verdicts; 0 = ignore pcoinc/ncoinc. The timestamp still runs.
- pcoinc  in  NREQ  per-cable prompt-coincidence pulse, 1 clk wide.
- ncoinc  in  NREQ  per-cable no-coincidence pulse, 1 clk wide.
- rd_strobe  in  1  pop the head word; 1-clk pulse from bus read decode.
- rd_data  out  32  FIFO head word (first-word-fall-through).
- empty  out  1  FIFO empty.
- full  out  1  FIFO holds DEPTH words.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- drop_cnt  out  16  saturating count of discarded events.
- clr_drop  in  1  synchronous clear of drop_cnt.

Behaviour:
- Reset (async, rst_n=0):
  - ts=0, all pending bits 0, rr_ptr=0, FIFO emptied.
  - empty=1, full=0, count=0, drop_cnt=0, rd_data=0.
- Timestamp:
  - ts increments by 1 every clk and wraps from 2^TSW-1 to 0.
  - The captured value is ts at the clock edge where the verdict is sampled.
- Capture (per requester i, when enable=1):
  - If pcoinc[i] or ncoinc[i] is high, load pend[i]=1, ptype[i]=pcoinc[i], pts[i]=ts.
  - If pcoinc[i] and ncoinc[i] are both high, the event is recorded as prompt (ptype=1).
  - If pend[i] is already 1 and is not being granted this cycle, the new event is discarded and drop_cnt increments.
  - If pend[i] is granted in the same cycle a new event arrives, the new event is loaded (no drop).
- Arbitration (combinational on pend, registered effect):
  - Search pend starting at rr_ptr, ascending, modulo NREQ.
  - The first set bit g is granted only if full=0.
  - On grant: push word, clear pend[g], set rr_ptr=(g+1) mod NREQ.
  - No grant: rr_ptr holds.
  - At most one push per clk.
- Word format: [31] ptype (1=prompt, 0=none); [30:28] source index; [27:24] 0; [23:0] pts, zero-extended.
- Latency: verdict at edge t → pend at t → push at t+1 (if granted) → empty=0 and rd_data valid after edge t+1. Minimum latency is 2 clks.
- FIFO:
  - Pop when rd_strobe=1 and empty=0; rd_strobe while empty is ignored (no underflow, no state change).
  - Push and pop in the same clk: both occur and count is unchanged.
  - When full=1, the push is blocked even if pop is asserted that cycle, so the registered full is the only gating signal.
  - Read/write pointers wrap modulo DEPTH.
  - rd_data shows mem[rd_ptr]; its value when empty=1 is don't-care.
- Backpressure: while full, pend bits remain held. Only new arrivals on already-pending requesters are dropped.
- drop_cnt:
  - Saturates at 16'hFFFF.
  - clr_drop wins over an increment in the same clk.
- enable=0: inputs are ignored and not counted as drops. Pending events still drain.
- Reset mid-operation: everything clears immediately. Pending events and FIFO contents are lost, and none are counted as drops.

Decomposition:
- Shared package mcu_pkg holds:
  - field positions EV_TYPE_BIT=31, EV_SRC_MSB=30, EV_SRC_LSB=28, EV_TS_MSB=23;
  - EV_W=32;
  - the source index constants SRC_A1..SRC_B4.
- Sub-module sync_fifo (parameters W, DEPTH): FWFT, push/pop/full/empty/count, async active-low reset.
- The round-robin search is a function in the package, not a module.

Test Plan:
- Single event: pcoinc[2]=1 at ts=100, enable=1 → after 2 clks empty=0, rd_data=32'hA000_0064. rd_strobe → empty=1.
- Simultaneous events: pcoinc[0], ncoinc[5], pcoinc[7] in one clk with rr_ptr=6 → FIFO order src 7, 0, 5; final rr_ptr=6; drop_cnt=0.
- Saturation: continuous ncoinc[1] every clk with no reads for DEPTH+3 clks → full=1, count=16, and drop_cnt increments on every clk after the FIFO fills. One pop → the held pend[1] word is pushed the next clk.
- Both high: pcoinc[3]=ncoinc[3]=1 → word bit31=1, src=3, one word only.
- Timestamp wrap: TSW=24 with event at ts=24'hFFFFFF, then another 2 clks later → pts values FFFFFF and 000001.
- Async reset: assert rst_n=0 mid-clk with 5 words queued → empty=1, count=0, drop_cnt=0 without waiting for a clock edge. Pre-reset events are not read back.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared MCU definitions: event word layout, cable source indices and the
// round-robin search used by the readout arbiter.
package mcu_pkg;

    localparam int EV_W        = 32;
    localparam int EV_TYPE_BIT = 31;
    localparam int EV_SRC_MSB  = 30;
    localparam int EV_SRC_LSB  = 28;
    localparam int EV_TS_MSB   = 23;

    localparam logic [2:0] SRC_A1 = 3'd0;
    localparam logic [2:0] SRC_A2 = 3'd1;
    localparam logic [2:0] SRC_A3 = 3'd2;
    localparam logic [2:0] SRC_A4 = 3'd3;
    localparam logic [2:0] SRC_B1 = 3'd4;
    localparam logic [2:0] SRC_B2 = 3'd5;
    localparam logic [2:0] SRC_B3 = 3'd6;
    localparam logic [2:0] SRC_B4 = 3'd7;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, ascending, wrapping modulo nreq.
    function automatic rr_pick_t rr_search(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         nreq);
        rr_pick_t   r;
        int         j;
        logic [2:0] j3;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < nreq && !r.hit) begin
                j  = (int'(ptr) + k) % nreq;
                j3 = 3'(j);
                if (req[j3]) begin
                    r.hit = 1'b1;
                    r.idx = j3;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; push ignored when full,
// pop ignored when empty. Head word reads as zero while empty.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/coinc_readout_arb.sv
// Time-stamps per-cable coincidence verdicts, holds one pending event per
// cable and round-robin arbitrates them into a shared readout FIFO.
module coinc_readout_arb
    import mcu_pkg::*;
#(
    parameter int NREQ  = 8,
    parameter int DEPTH = 16,
    parameter int TSW   = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NREQ-1:0]         pcoinc,
    input  logic [NREQ-1:0]         ncoinc,
    input  logic                    rd_strobe,
    output logic [EV_W-1:0]         rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic [15:0]             drop_cnt,
    input  logic                    clr_drop
);
    logic [TSW-1:0]             ts;
    logic [NREQ-1:0]            pend, ptype, gnt_oh, drop_vec;
    logic [NREQ-1:0][TSW-1:0]   pts;
    logic [2:0]                 rr_ptr;
    rr_pick_t                   pick;
    logic                       grant;
    logic [EV_W-1:0]            push_word;
    logic [16:0]                drop_sum;

    assign pick  = rr_search(8'(pend), rr_ptr, NREQ);
    assign grant = pick.hit && !full;

    // One-hot grant and the event word for the winning requester.
    always_comb begin
        gnt_oh    = '0;
        push_word = '0;
        if (grant) gnt_oh[pick.idx] = 1'b1;
        push_word[EV_TYPE_BIT]            = ptype[pick.idx];
        push_word[EV_SRC_MSB:EV_SRC_LSB]  = pick.idx;
        push_word[EV_TS_MSB:0]            = 24'(pts[pick.idx]);
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        logic           hit, pend_q, ptype_q;
        logic [TSW-1:0] pts_q;

        assign hit         = enable && (pcoinc[i] || ncoinc[i]);
        // A slot being granted this cycle frees up in time for the new event.
        assign drop_vec[i] = hit && pend_q && !gnt_oh[i];
        assign pend[i]     = pend_q;
        assign ptype[i]    = ptype_q;
        assign pts[i]      = pts_q;

        // Pending slot: load on a verdict, clear on grant, hold otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_q  <= 1'b0;
                ptype_q <= 1'b0;
                pts_q   <= '0;
            end else if (hit && !drop_vec[i]) begin
                pend_q  <= 1'b1;
                ptype_q <= pcoinc[i];
                pts_q   <= ts;
            end else if (gnt_oh[i]) begin
                pend_q  <= 1'b0;
            end
        end
    end

    // Free-running timestamp and round-robin pointer advance past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts     <= '0;
            rr_ptr <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (grant)
                rr_ptr <= (32'(pick.idx) == NREQ - 1) ? 3'd0 : pick.idx + 3'd1;
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + 17'($countones(drop_vec));

    // Saturating drop counter; a clear beats any same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           drop_cnt <= '0;
        else if (clr_drop)    drop_cnt <= '0;
        else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
        else                  drop_cnt <= drop_sum[15:0];
    end

    sync_fifo #(.W(EV_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .pop   (rd_strobe),
        .din   (push_word),
        .dout  (rd_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_coinc_readout_arb.sv
// Directed bench for coinc_readout_arb; a second small-timestamp instance
// exercises timestamp wrap-around.
module tb_coinc_readout_arb;
    logic        clk, rst_n, enable, rd_strobe, clr_drop;
    logic [7:0]  pcoinc, ncoinc;
    logic [31:0] rd_data;
    logic        empty, full;
    logic [4:0]  count;
    logic [15:0] drop_cnt;

    logic        w_rd_strobe;
    logic [7:0]  w_pcoinc, w_ncoinc;
    logic [31:0] w_rd_data;
    logic        w_empty, w_full;
    logic [4:0]  w_count;
    logic [15:0] w_drop_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    logic [23:0] exp_ts;
    logic [7:0]  exp_hi [3];

    coinc_readout_arb #(.NREQ(8), .DEPTH(16), .TSW(24)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pcoinc(pcoinc),
        .ncoinc(ncoinc), .rd_strobe(rd_strobe), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .drop_cnt(drop_cnt),
        .clr_drop(clr_drop)
    );

    coinc_readout_arb #(.NREQ(8), .DEPTH(16), .TSW(4)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .enable(1'b1), .pcoinc(w_pcoinc),
        .ncoinc(w_ncoinc), .rd_strobe(w_rd_strobe), .rd_data(w_rd_data),
        .empty(w_empty), .full(w_full), .count(w_count),
        .drop_cnt(w_drop_cnt), .clr_drop(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release, equal to the timestamp sampled at the next edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic pop1();
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; rd_strobe = 1'b0; clr_drop = 1'b0;
        pcoinc = '0; ncoinc = '0;
        w_rd_strobe = 1'b0; w_pcoinc = '0; w_ncoinc = '0;

        // reset state
        #2;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_w_empty", 32'(w_empty), 32'd1);

        // timestamp wrap on the 4-bit instance: events at ts=F and ts=1
        @(negedge clk); rst_n = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk); w_pcoinc = 8'h01;
        @(negedge clk); w_pcoinc = 8'h00;
        @(negedge clk); w_ncoinc = 8'h01;
        @(negedge clk); w_ncoinc = 8'h00;
        check("wrap_word0", w_rd_data, 32'h8000_000F);
        w_rd_strobe = 1'b1;
        @(negedge clk); w_rd_strobe = 1'b0;
        check("wrap_word1", w_rd_data, 32'h0000_0001);
        check("wrap_count", 32'(w_count), 32'd1);
        w_rd_strobe = 1'b1;
        @(negedge clk); w_rd_strobe = 1'b0;
        check("wrap_empty", 32'(w_empty), 32'd1);

        // single event at ts=100, two-clock latency
        do_reset();
        repeat (100) @(posedge clk);
        @(negedge clk); pcoinc = 8'h04;
        @(negedge clk); pcoinc = 8'h00;
        check("single_lat_empty", 32'(empty), 32'd1);
        @(negedge clk);
        check("single_empty", 32'(empty), 32'd0);
        check("single_word", rd_data, 32'hA000_0064);
        pop1();
        check("single_pop_empty", 32'(empty), 32'd1);
        check("single_pop_count", 32'(count), 32'd0);

        // move rr_ptr to 6 by granting source 5
        ncoinc = 8'h20;
        @(negedge clk); ncoinc = 8'h00;
        @(negedge clk);
        pop1();

        // simultaneous events with rr_ptr=6: order 7, 0, 5
        exp_ts = cyc[23:0];
        pcoinc = 8'h81; ncoinc = 8'h20;
        @(negedge clk); pcoinc = 8'h00; ncoinc = 8'h00;
        repeat (3) @(negedge clk);
        check("sim_count", 32'(count), 32'd3);
        exp_hi[0] = 8'hF0; exp_hi[1] = 8'h80; exp_hi[2] = 8'h50;
        for (int i = 0; i < 3; i++) begin
            check("sim_word", rd_data, {exp_hi[i], exp_ts});
            pop1();
        end
        check("sim_drop", 32'(drop_cnt), 32'd0);

        // rr_ptr back at 6: source 6 beats source 5
        exp_ts = cyc[23:0];
        pcoinc = 8'h60;
        @(negedge clk); pcoinc = 8'h00;
        repeat (2) @(negedge clk);
        check("rr_count", 32'(count), 32'd2);
        check("rr_word6", rd_data, {8'hE0, exp_ts});
        pop1();
        check("rr_word5", rd_data, {8'hD0, exp_ts});
        pop1();

        // saturation: ncoinc[1] every clock, no reads
        ncoinc = 8'h02;
        repeat (17) @(negedge clk);
        check("sat_count", 32'(count), 32'd16);
        check("sat_full", 32'(full), 32'd1);
        check("sat_drop0", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        check("sat_drop1", 32'(drop_cnt), 32'd1);
        @(negedge clk);
        check("sat_drop2", 32'(drop_cnt), 32'd2);
        ncoinc = 8'h00;
        pop1();
        check("sat_pop_count", 32'(count), 32'd15);
        check("sat_pop_full", 32'(full), 32'd0);
        @(negedge clk);
        check("sat_refill_count", 32'(count), 32'd16);
        check("sat_refill_drop", 32'(drop_cnt), 32'd2);

        // clear beats a same-cycle drop
        ncoinc = 8'h02;
        @(negedge clk); clr_drop = 1'b1;
        @(negedge clk); clr_drop = 1'b0;
        check("clr_wins", 32'(drop_cnt), 32'd0);
        @(negedge clk); ncoinc = 8'h00;
        check("drop_after_clr", 32'(drop_cnt), 32'd1);

        // drain everything, strobes past empty are ignored
        rd_strobe = 1'b1;
        repeat (20) @(negedge clk);
        rd_strobe = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // both pulses high on one cable: one prompt word
        exp_ts = cyc[23:0];
        pcoinc = 8'h08; ncoinc = 8'h08;
        @(negedge clk); pcoinc = 8'h00; ncoinc = 8'h00;
        @(negedge clk);
        check("both_word", rd_data, {8'hB0, exp_ts});
        pop1();
        @(negedge clk);
        check("both_one_word", 32'(count), 32'd0);

        // enable=0 ignores verdicts and does not count drops
        enable = 1'b0;
        pcoinc = 8'hFF;
        @(negedge clk); pcoinc = 8'h00;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        check("dis_empty", 32'(empty), 32'd1);
        check("dis_drop", 32'(drop_cnt), 32'd1);

        // async reset with five words queued plus one pending
        pcoinc = 8'h1F;
        @(negedge clk); pcoinc = 8'h00;
        repeat (6) @(negedge clk);
        check("pre_rst_count", 32'(count), 32'd5);
        pcoinc = 8'h80;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_count", 32'(count), 32'd0);
        check("arst_drop", 32'(drop_cnt), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        pcoinc = 8'h00;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_empty", 32'(empty), 32'd1);
        check("post_rst_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
